fan_tachometer: RTL and testbench
=================================

Name: fan_tachometer

Overview:
Converts one raw open-drain fan tach input into a 16-bit RPM value, refreshed once per fixed measurement window. It sits directly upstream of the system-info APB register block and drives its fan0_rpm / fan1_rpm inputs. The design uses one instance per fan. The block handles asynchronous-input synchronization, glitch filtering, edge counting and scaling to RPM with saturation.

Parameters:
WINDOW_CYCLES, 125000000, measurement window length in clk cycles (default is 1 s at 125 MHz).
RPM_SCALE, 30, multiplier from edges-per-window to RPM: 60 / (pulses_per_rev × window_seconds). Default assumes 2 pulses/rev and a 1 s window.
DEBOUNCE_CYCLES, 1000, number of consecutive stable cycles needed before the filtered level changes.
CNT_W, 16, width of the edge counter.
STALL_WINDOWS, 2, number of consecutive zero-edge windows before stall is flagged (optional feature only).

Ports:
clk  in  1  system clock; all logic is in this domain.
rst_n  in  1  asynchronous active-low reset.
tach  in  1  raw tach pin, asynchronous to clk; idles high because of the pull-up.
rpm  out  16  last completed-window RPM, saturated.
rpm_valid  out  1  high once at least one window has completed since reset.
rpm_update  out  1  one-cycle strobe, high in the same cycle rpm is loaded.
stall  out  1  fan stall flag (optional feature); tied 0 when the feature is compiled out.

Behaviour:
- Reset (asynchronous, rst_n low):
  - rpm = 0, rpm_valid = 0, rpm_update = 0, stall = 0.
  - Synchronizer flops and filtered level reset to 1, so there is no spurious rising edge after reset.
  - Window counter and edge counter reset to 0.
- Reset deasserted mid-window discards that partial window; the window restarts from count 0.
- Synchronizer: 2-FF on tach.
- Debounce:
  - A stability counter counts cycles where the synchronized input differs from the filtered level.
  - When the counter reaches DEBOUNCE_CYCLES, the filtered level flips and the counter clears.
  - Any cycle where the input equals the filtered level clears the counter.
  - Pulses shorter than DEBOUNCE_CYCLES are never seen.
- Edge detect: a rising edge of the filtered level produces a 1-cycle edge pulse.
  - Latency from pin edge to edge pulse is 2 + DEBOUNCE_CYCLES cycles (±1).
- Window counter:
  - Counts 0 .. WINDOW_CYCLES-1, then wraps.
  - The cycle where count == WINDOW_CYCLES-1 is the terminal cycle.
- Edge counter:
  - Increments on each edge pulse.
  - Saturates at 2^CNT_W-1 and does not wrap.
- On the terminal cycle:
  - Compute product = edge_count × RPM_SCALE at full width (CNT_W + clog2(RPM_SCALE+1) bits).
  - rpm <= 16'hFFFF if product > 65535, else product[15:0]. The value is registered and visible the next cycle, together with rpm_update = 1.
  - rpm_valid <= 1 (sticky until reset).
  - The edge counter reloads to 1 if an edge pulse coincides with the terminal cycle, else to 0. That edge belongs to the new window.
- rpm holds its value between updates.
- rpm_update is high for exactly one cycle every WINDOW_CYCLES cycles.
- No handshake: consumers sample rpm combinationally at any time.

Optional Feature:
Macro FAN_TACHOMETER_STALL_EN.
- When defined, a zero-window counter runs:
  - At each window completion with 0 edges, the counter increments, saturating at STALL_WINDOWS.
  - When it reaches STALL_WINDOWS, stall <= 1 in the same cycle as rpm_update.
  - At the first completed window with a nonzero count, the counter clears and stall <= 0.
- When undefined, stall is constant 0 and no counter logic is synthesized.

Decomposition:
- Package fan_tach_pkg holds:
  - The RPM_MAX constant (16'hFFFF).
  - A function computing the product width from CNT_W and RPM_SCALE.
  - The saturating-scale function used by the top level.
- Sub-module tach_debounce contains the synchronizer, debounce counter and filtered level. It is parameterized by DEBOUNCE_CYCLES, has ports clk, rst_n, din and dout, and is reusable for other slow inputs.
- Top level contains the edge detect, window logic, scaling and stall logic.

Test Plan:
Sim parameters for all tests: WINDOW_CYCLES=1000, RPM_SCALE=30, DEBOUNCE_CYCLES=4.
- Reset, tach held high, 3 windows:
  - rpm=0 and rpm_valid=0 until the first strobe.
  - rpm_update pulses at window ends (cycles 1000, 2000, 3000 after reset release).
  - rpm stays 0.
- 10 clean pulses (20 cycles high / 20 cycles low) per window: rpm=300 at each strobe; rpm_valid=1.
- Glitch filtering: 10 clean pulses plus 15 glitches 2 cycles wide: rpm=300 (glitches not counted).
- Saturation with RPM_SCALE=1000: 80 pulses in one window gives rpm=16'hFFFF (not 80000 mod 65536 = 14464).
- Boundary: a filtered edge timed to land on the terminal cycle is excluded from the closing window's rpm and included in the next window's count. Previous count 5 gives rpm=150; the next window of 5 pulses gives rpm=180.
- Stall (macro defined) and mid-window reset:
  - 2 windows with no edges gives stall=1 at the second strobe.
  - A window of 3 pulses then gives stall=0 and rpm=90.
  - Asserting rst_n low at cycle 500 of a window clears rpm, rpm_valid and stall immediately.

Source files
------------

// File: rtl/fan_tach_pkg.sv
// rtl/fan_tach_pkg.sv - shared constants and scaling helpers for the fan tachometer
package fan_tach_pkg;

  localparam logic [15:0] RPM_MAX = 16'hFFFF;

  // Width needed to hold edge_count * scale without loss.
  function automatic int prod_width(input int cnt_w, input int scale);
    return cnt_w + $clog2(scale + 1);
  endfunction

  // Clamp a full-width edges-times-scale product to the 16-bit RPM range.
  function automatic logic [15:0] sat_rpm(input logic [63:0] product);
    if (product > 64'(RPM_MAX)) begin
      return RPM_MAX;
    end
    return product[15:0];
  endfunction

endpackage

// File: rtl/tach_debounce.sv
// rtl/tach_debounce.sv - 2-FF synchronizer plus stability-count glitch filter for slow inputs
module tach_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] stable_cnt;

  // Two-flop synchronizer; resets high to match the pulled-up idle pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
    end
  end

  // Flip the filtered level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level      <= 1'b1;
      stable_cnt <= '0;
    end else if (sync2 == level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      level      <= sync2;
      stable_cnt <= '0;
    end else begin
      stable_cnt <= stable_cnt + CW'(1);
    end
  end

  assign dout = level;

endmodule

// File: rtl/fan_tachometer.sv
// rtl/fan_tachometer.sv - fan tach to 16-bit RPM converter; stall flag built only with FAN_TACHOMETER_STALL_EN
module fan_tachometer #(
  parameter int WINDOW_CYCLES   = 125000000,
  parameter int RPM_SCALE       = 30,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16,
  parameter int STALL_WINDOWS   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tach,
  output logic [15:0] rpm,
  output logic        rpm_valid,
  output logic        rpm_update,
  output logic        stall
);
  import fan_tach_pkg::*;

  localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam int PROD_W = prod_width(CNT_W, RPM_SCALE);

  // Reject configurations the window/stall logic cannot represent.
  if (WINDOW_CYCLES < 2 || DEBOUNCE_CYCLES < 1 || STALL_WINDOWS < 1 || PROD_W > 64) begin : g_bad_params
    $error("fan_tachometer: unsupported parameter combination");
  end

  logic              tach_level;
  logic              level_q;
  logic              edge_pulse;
  logic              terminal;
  logic [WIN_W-1:0]  win_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic [PROD_W-1:0] product;

  tach_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (tach),
    .dout (tach_level)
  );

  assign edge_pulse = tach_level & ~level_q;
  assign terminal   = (win_cnt == WIN_LAST);
  assign product    = PROD_W'(edge_cnt) * PROD_W'(RPM_SCALE);

  // Delayed filtered level for rising-edge detection; resets high so reset is edge-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b1;
    end else begin
      level_q <= tach_level;
    end
  end

  // Free-running measurement window 0 .. WINDOW_CYCLES-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt <= '0;
    end else if (terminal) begin
      win_cnt <= '0;
    end else begin
      win_cnt <= win_cnt + WIN_W'(1);
    end
  end

  // Saturating edge counter; an edge on the terminal cycle opens the next window's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_cnt <= '0;
    end else if (terminal) begin
      edge_cnt <= CNT_W'(edge_pulse);
    end else if (edge_pulse && (edge_cnt != {CNT_W{1'b1}})) begin
      edge_cnt <= edge_cnt + CNT_W'(1);
    end
  end

  // Load the scaled, saturated RPM at window close and strobe the update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpm        <= '0;
      rpm_valid  <= 1'b0;
      rpm_update <= 1'b0;
    end else begin
      rpm_update <= terminal;
      if (terminal) begin
        rpm       <= sat_rpm(64'(product));
        rpm_valid <= 1'b1;
      end
    end
  end

`ifdef FAN_TACHOMETER_STALL_EN
  localparam int ZW = $clog2(STALL_WINDOWS + 1);

  logic [ZW-1:0] zero_cnt;
  logic          stall_q;

  // Count consecutive empty windows; flag stall once STALL_WINDOWS is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_cnt <= '0;
      stall_q  <= 1'b0;
    end else if (terminal) begin
      if (edge_cnt == '0) begin
        if (zero_cnt < ZW'(STALL_WINDOWS)) begin
          zero_cnt <= zero_cnt + ZW'(1);
        end
        if (zero_cnt >= ZW'(STALL_WINDOWS - 1)) begin
          stall_q <= 1'b1;
        end
      end else begin
        zero_cnt <= '0;
        stall_q  <= 1'b0;
      end
    end
  end

  assign stall = stall_q;
`else
  assign stall = 1'b0;
`endif

endmodule

// File: tb/tb_fan_tachometer.sv
// tb/tb_fan_tachometer.sv - directed self-checking bench for fan_tachometer
module tb_fan_tachometer;

  localparam int WIN = 1000;

`ifdef FAN_TACHOMETER_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tach = 1'b1;
  logic [15:0] rpm;
  logic        rpm_valid;
  logic        rpm_update;
  logic        stall;
  logic [15:0] rpm_s;
  logic        rpm_valid_s;
  logic        rpm_update_s;
  logic        stall_s;

  int checks = 0;
  int errors = 0;

  // bench-side model state
  int carry     = 0;
  int zero_wins = 0;
  int prev_rpm   = 0;
  int prev_rpm_s = 0;
  bit exp_valid  = 1'b0;
  bit exp_stall  = 1'b0;

  always #5 clk = ~clk;

  fan_tachometer #(
    .WINDOW_CYCLES(WIN), .RPM_SCALE(30), .DEBOUNCE_CYCLES(4), .CNT_W(16), .STALL_WINDOWS(2)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .tach(tach), .rpm(rpm),
    .rpm_valid(rpm_valid), .rpm_update(rpm_update), .stall(stall)
  );

  fan_tachometer #(
    .WINDOW_CYCLES(WIN), .RPM_SCALE(1000), .DEBOUNCE_CYCLES(4), .CNT_W(16), .STALL_WINDOWS(2)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .tach(tach), .rpm(rpm_s),
    .rpm_valid(rpm_valid_s), .rpm_update(rpm_update_s), .stall(stall_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_state();
    check("rst_rpm", rpm, 0);
    check("rst_valid", rpm_valid, 0);
    check("rst_update", rpm_update, 0);
    check("rst_stall", stall, 0);
    check("rst_rpm_sat", rpm_s, 0);
    check("rst_valid_sat", rpm_valid_s, 0);
  endtask

  // One full window starting just after a window-start edge. Pulses: low for lo cycles
  // every per cycles from t=10; glitches: 2-cycle lows every 20 cycles from t=500;
  // boundary: a long low released at t=993 so its filtered edge lands on the terminal cycle.
  task automatic run_window(input string name, input int n, input int per, input int lo,
                            input int glitches, input bit boundary);
    int total;
    int exp_r;
    int exp_s;
    for (int t = 0; t < WIN; t++) begin
      logic v;
      v = 1'b1;
      if (n > 0 && t >= 10 && t < 10 + n * per && ((t - 10) % per) < lo) v = 1'b0;
      if (t >= 500 && t < 500 + glitches * 20 && ((t - 500) % 20) < 2) v = 1'b0;
      if (boundary && t >= 900 && t < 993) v = 1'b0;
      tach = v;
      if (t == 1) check({name, "_update_low"}, rpm_update, 0);
      if (t == 500) begin
        check({name, "_hold"}, rpm, prev_rpm);
        check({name, "_hold_sat"}, rpm_s, prev_rpm_s);
        check({name, "_valid_mid"}, rpm_valid, exp_valid);
      end
      if (t == WIN - 1) check({name, "_no_early_update"}, rpm_update, 0);
      @(posedge clk);
      #1;
    end
    total = n + carry;
    carry = boundary ? 1 : 0;
    exp_r = total * 30;
    exp_s = (total * 1000 > 65535) ? 65535 : total * 1000;
    if (total == 0) begin
      if (zero_wins < 2) zero_wins++;
      exp_stall = STALL_ON && (zero_wins >= 2);
    end else begin
      zero_wins = 0;
      exp_stall = 1'b0;
    end
    exp_valid = 1'b1;
    check({name, "_update"}, rpm_update, 1);
    check({name, "_update_sat"}, rpm_update_s, 1);
    check({name, "_rpm"}, rpm, exp_r);
    check({name, "_rpm_sat"}, rpm_s, exp_s);
    check({name, "_valid"}, rpm_valid, 1);
    check({name, "_stall"}, stall, exp_stall);
    prev_rpm   = exp_r;
    prev_rpm_s = exp_s;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check_reset_state();
    rst_n = 1'b1;

    run_window("idle1", 0, 40, 20, 0, 1'b0);
    run_window("idle2", 0, 40, 20, 0, 1'b0);
    run_window("idle3", 0, 40, 20, 0, 1'b0);
    run_window("clean1", 10, 40, 20, 0, 1'b0);
    run_window("clean2", 10, 40, 20, 0, 1'b0);
    run_window("glitch", 10, 40, 20, 15, 1'b0);
    run_window("sat80", 80, 12, 6, 0, 1'b0);
    run_window("bndA", 5, 40, 20, 0, 1'b1);
    run_window("bndB", 5, 40, 20, 0, 1'b0);
    run_window("stall1", 0, 40, 20, 0, 1'b0);
    run_window("stall2", 0, 40, 20, 0, 1'b0);
    run_window("three", 3, 40, 20, 0, 1'b0);
    run_window("stall3", 0, 40, 20, 0, 1'b0);
    run_window("stall4", 0, 40, 20, 0, 1'b0);

    // Mid-window reset: outputs clear immediately, partial window discarded.
    tach = 1'b1;
    repeat (500) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_state();
    check("rst_stall_sat", stall_s, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    carry      = 0;
    zero_wins  = 0;
    prev_rpm   = 0;
    prev_rpm_s = 0;
    exp_valid  = 1'b0;
    run_window("post_rst", 2, 40, 20, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
